// File: rtl/xor_bind_checker.sv
// Protocol checker: verifies c == a^b delayed by LATENCY cycles and keeps a sticky
// fault state, a saturating mismatch count and the cycle stamp of the first failure.
module xor_bind_checker #(
   parameter int LATENCY = 1,
   parameter int CNT_W   = 8,
   parameter int CYC_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic [1:0]       state,
   output logic             err_pulse,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic [CYC_W-1:0] first_cyc,
   output logic [CYC_W-1:0] cyc
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      CHECK  = 2'd2,
      FAULT  = 2'd3
   } state_t;

   state_t           st, st_nxt;
   logic             tail_vld, tail_exp;
   logic             cmp, mis;
   logic [CYC_W-1:0] cyc_eff;

   generate
      if (LATENCY == 0) begin : g_comb
         assign tail_vld = en;
         assign tail_exp = a ^ b;
      end else begin : g_pipe
         logic [LATENCY-1:0] vld;
         logic [LATENCY-1:0] xp;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld <= '0;
               xp  <= '0;
            end else begin
               vld[0] <= en & ~clear;
               xp[0]  <= a ^ b;
               for (int unsigned i = 1; i < LATENCY; i++) begin
                  vld[i] <= vld[i-1] & ~clear;
                  xp[i]  <= xp[i-1];
               end
            end
         end

         assign tail_vld = vld[LATENCY-1];
         assign tail_exp = xp[LATENCY-1];
      end
   endgenerate

   assign cmp = en & tail_vld;
   assign mis = cmp & (c ^ tail_exp);

   // Leaving IDLE restarts the cycle count; the leaving cycle itself is cycle 0.
   assign cyc_eff = (st == IDLE) ? '0 : cyc;

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE: begin
            if (mis)      st_nxt = FAULT;
            else if (en)  st_nxt = cmp ? CHECK : WARMUP;
         end
         WARMUP: begin
            if (mis)      st_nxt = FAULT;
            else if (!en) st_nxt = IDLE;
            else if (cmp) st_nxt = CHECK;
         end
         CHECK: begin
            if (mis)      st_nxt = FAULT;
            else if (!en) st_nxt = IDLE;
         end
         FAULT:           st_nxt = FAULT;
         default:         st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         err_pulse <= 1'b0;
         err_count <= '0;
         first_cyc <= '0;
         cyc       <= '0;
      end else if (clear) begin
         st        <= IDLE;
         err_pulse <= 1'b0;
         err_count <= '0;
         first_cyc <= '0;
         cyc       <= '0;
      end else begin
         st        <= st_nxt;
         err_pulse <= mis;
         if (mis) begin
            if (err_count == '0) first_cyc <= cyc_eff;
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
         end
         if (en) cyc <= cyc_eff + CYC_W'(1);
      end
   end

   assign state = st;
   assign err   = (st == FAULT);

endmodule

// File: tb/tb_xor_bind_checker.sv
// Scoreboard bench for xor_bind_checker: three instances (LATENCY 1, LATENCY 1 with
// a 2-bit counter, LATENCY 0) share stimulus and are checked against a history model.
module tb_xor_bind_checker;

   logic       clk = 1'b0;
   logic       rst_n, en, clear, a, b;
   logic [2:0] c;

   logic [1:0]  st0, st1, st2;
   logic        pl0, pl1, pl2, er0, er1, er2;
   logic [7:0]  cnt0, cnt2;
   logic [1:0]  cnt1;
   logic [15:0] fc0, fc1, fc2, cy0, cy1, cy2;

   xor_bind_checker #(.LATENCY(1), .CNT_W(8), .CYC_W(16)) u_l1 (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b), .c(c[0]),
      .state(st0), .err_pulse(pl0), .err(er0), .err_count(cnt0), .first_cyc(fc0), .cyc(cy0));

   xor_bind_checker #(.LATENCY(1), .CNT_W(2), .CYC_W(16)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b), .c(c[1]),
      .state(st1), .err_pulse(pl1), .err(er1), .err_count(cnt1), .first_cyc(fc1), .cyc(cy1));

   xor_bind_checker #(.LATENCY(0), .CNT_W(8), .CYC_W(16)) u_l0 (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b), .c(c[2]),
      .state(st2), .err_pulse(pl2), .err(er2), .err_count(cnt2), .first_cyc(fc2), .cyc(cy2));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  st;
      logic        pulse;
      logic        err;
      logic [15:0] cnt;
      logic [15:0] first;
      logic [15:0] cyc;
   } obs_t;
   typedef obs_t [2:0] obs3_t;

   obs3_t sb_q[$];
   int    tests = 0;
   int    fails = 0;

   int lat[3]  = '{1, 1, 0};
   int cntw[3] = '{8, 2, 8};

   // Model: per-instance outcome counters plus the raw history of (en, a^b) per cycle.
   int m_st[3], m_cnt[3], m_first[3], m_cyc[3];
   bit m_pulse[3];
   bit h_en[$];
   bit h_x[$];
   int flush_t = -1;

   function automatic void model_zero(int k);
      m_st[k] = 0; m_cnt[k] = 0; m_first[k] = 0; m_cyc[k] = 0; m_pulse[k] = 1'b0;
   endfunction

   function automatic bit compare_event(int k, bit e);
      int idx;
      if (lat[k] == 0) return e;
      idx = h_x.size() - lat[k];
      return e && idx >= 0 && idx > flush_t && h_en[idx];
   endfunction

   function automatic bit expected_x(int k, bit x);
      int idx;
      if (lat[k] == 0) return x;
      idx = h_x.size() - lat[k];
      return (idx >= 0) ? h_x[idx] : 1'b0;
   endfunction

   function automatic void model_step(int k, bit e, bit x, bit cv, bit clr);
      bit ev, mis;
      int eff, sat;
      ev  = compare_event(k, e);
      mis = ev && (cv != expected_x(k, x));
      sat = (1 << cntw[k]) - 1;
      if (clr) begin
         model_zero(k);
         return;
      end
      eff = (m_st[k] == 0) ? 0 : m_cyc[k];
      m_pulse[k] = mis;
      if (mis) begin
         if (m_cnt[k] == 0) m_first[k] = eff;
         if (m_cnt[k] < sat) m_cnt[k]++;
      end
      if (e) m_cyc[k] = (eff + 1) % 65536;
      if (m_st[k] != 3) begin
         if (mis)               m_st[k] = 3;
         else if (m_st[k] == 0) m_st[k] = e ? (ev ? 2 : 1) : 0;
         else if (!e)           m_st[k] = 0;
         else if (ev)           m_st[k] = 2;
      end
   endfunction

   function automatic obs_t model_obs(int k);
      obs_t o;
      o.st    = 2'(m_st[k]);
      o.pulse = m_pulse[k];
      o.err   = (m_st[k] == 3);
      o.cnt   = 16'(m_cnt[k]);
      o.first = 16'(m_first[k]);
      o.cyc   = 16'(m_cyc[k]);
      return o;
   endfunction

   task automatic tick(input bit e, input bit clr, input bit [2:0] bad,
                       input bit rst, input bit apulse);
      bit    x;
      bit [2:0] cv;
      obs3_t ex;
      a = 1'($urandom);
      b = 1'($urandom);
      x = a ^ b;
      if (apulse) begin
         for (int k = 0; k < 3; k++) model_zero(k);
         flush_t = h_x.size() - 1;
      end
      for (int k = 0; k < 3; k++) cv[k] = expected_x(k, x) ^ bad[k];
      en    = e;
      clear = clr;
      c     = cv;
      rst_n = !rst;
      if (apulse) begin
         #1 rst_n = 1'b0;
         #2 rst_n = 1'b1;
      end
      if (rst) begin
         for (int k = 0; k < 3; k++) model_zero(k);
         flush_t = h_x.size();
      end else begin
         for (int k = 0; k < 3; k++) model_step(k, e, x, cv[k], clr);
         if (clr) flush_t = h_x.size();
      end
      for (int k = 0; k < 3; k++) ex[k] = model_obs(k);
      sb_q.push_back(ex);
      h_en.push_back(e);
      h_x.push_back(x);
      @(posedge clk);
      #2;
   endtask

   // Monitor: one expected record per clock edge, sampled 1 time unit after the edge.
   initial begin
      obs3_t ex, got;
      forever begin
         @(posedge clk);
         #1;
         got[0] = '{st: st0, pulse: pl0, err: er0, cnt: 16'(cnt0), first: fc0, cyc: cy0};
         got[1] = '{st: st1, pulse: pl1, err: er1, cnt: 16'(cnt1), first: fc1, cyc: cy1};
         got[2] = '{st: st2, pulse: pl2, err: er2, cnt: 16'(cnt2), first: fc2, cyc: cy2};
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_underflow at %0t: got no expectation, required one", $time);
         end else begin
            ex = sb_q.pop_front();
            for (int k = 0; k < 3; k++) begin
               tests++;
               if (got[k] !== ex[k]) begin
                  fails++;
                  $display("FAIL inst%0d at %0t: got st=%0d pulse=%0b err=%0b cnt=%0d first=%0d cyc=%0d, required st=%0d pulse=%0b err=%0b cnt=%0d first=%0d cyc=%0d",
                           k, $time, got[k].st, got[k].pulse, got[k].err, got[k].cnt, got[k].first, got[k].cyc,
                           ex[k].st, ex[k].pulse, ex[k].err, ex[k].cnt, ex[k].first, ex[k].cyc);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; clear = 1'b0; a = 1'b0; b = 1'b0; c = '0;

      for (int i = 0; i < 3; i++)  tick(1'($urandom), 1'b0, 3'b000, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++)  tick(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      // clean stream
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      // single fault at the 6th enabled cycle, then clean cycles
      tick(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, (i == 5) ? 3'b111 : 3'b000, 1'b0, 1'b0);
      // asynchronous reset pulse between edges
      tick(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
      // back-to-back mismatches for saturation
      for (int i = 0; i < 7; i++)  tick(1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
      // clear coinciding with a mismatch, then re-enable
      tick(1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)  tick(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      // en dropped mid-stream with a wrong c
      tick(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)  tick(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++)  tick(1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)  tick(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         bit [2:0] bad;
         for (int k = 0; k < 3; k++) bad[k] = ($urandom_range(99) < 3);
         tick($urandom_range(99) < 85, $urandom_range(99) < 4, bad, 1'b0, 1'b0);
      end

      if (sb_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
